// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory upload port for the program loader.
// master = stream source / memory side, slave = loader.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready;
  logic        iwr_en;
  logic [31:0] iwr_addr;
  logic [31:0] iwr_data;

  modport master (
    output byte_valid, byte_in,
    input  byte_ready, iwr_en, iwr_addr, iwr_data
  );

  modport slave (
    input  byte_valid, byte_in,
    output byte_ready, iwr_en, iwr_addr, iwr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: assembles little-endian 32-bit words from a byte stream and writes
// them into instruction memory, holding the core stalled until the load completes.
module imem_loader #(
  parameter int unsigned DEPTH = 20,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W:0]   n_words,
  imem_loader_if.slave     bus,
  output logic             core_hold,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W:0] ONE_W   = (CNT_W+1)'(1);

  state_t           r_state;
  logic [CNT_W:0]   r_nw;
  logic [CNT_W-1:0] r_idx;
  logic [1:0]       r_bcnt;
  logic [23:0]      r_lo;
  logic             r_byte_ready;
  logic             r_iwr_en;
  logic [31:0]      r_iwr_addr;
  logic [31:0]      r_iwr_data;
  logic             r_core_hold;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [31:0]      r_checksum;

  logic             w_count_ok;
  logic             w_last_word;

  assign w_count_ok  = (n_words != '0) && (n_words <= DEPTH_C);
  assign w_last_word = ({1'b0, r_idx} == (r_nw - ONE_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_nw         <= '0;
      r_idx        <= '0;
      r_bcnt       <= '0;
      r_lo         <= '0;
      r_byte_ready <= 1'b0;
      r_iwr_en     <= 1'b0;
      r_iwr_addr   <= '0;
      r_iwr_data   <= '0;
      r_core_hold  <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_checksum   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_core_hold <= 1'b1;
            r_done      <= 1'b0;
            if (w_count_ok) begin
              r_state      <= S_RECV;
              r_nw         <= n_words;
              r_idx        <= '0;
              r_bcnt       <= '0;
              r_checksum   <= '0;
              r_err        <= 1'b0;
              r_busy       <= 1'b1;
              r_byte_ready <= 1'b1;
            end else begin
              r_state      <= S_ERR;
              r_err        <= 1'b1;
              r_busy       <= 1'b0;
              r_byte_ready <= 1'b0;
            end
          end
        end

        S_RECV: begin
          if (bus.byte_valid) begin
            r_bcnt <= r_bcnt + 2'd1;
            case (r_bcnt)
              2'd0: r_lo[7:0]   <= bus.byte_in;
              2'd1: r_lo[15:8]  <= bus.byte_in;
              2'd2: r_lo[23:16] <= bus.byte_in;
              default: begin
                // The 4th byte goes straight into the write word, never into r_lo.
                r_state      <= S_WRITE;
                r_byte_ready <= 1'b0;
                r_iwr_en     <= 1'b1;
                r_iwr_data   <= {bus.byte_in, r_lo};
                r_iwr_addr   <= {{(30-CNT_W){1'b0}}, r_idx, 2'b00};
              end
            endcase
          end
        end

        S_WRITE: begin
          r_iwr_en   <= 1'b0;
          r_checksum <= r_checksum ^ r_iwr_data;
          r_idx      <= r_idx + CNT_W'(1);
          if (w_last_word) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_core_hold <= 1'b0;
          end else begin
            r_state      <= S_RECV;
            r_bcnt       <= '0;
            r_byte_ready <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.iwr_en     = r_iwr_en;
  assign bus.iwr_addr   = r_iwr_addr;
  assign bus.iwr_data   = r_iwr_data;
  assign core_hold      = r_core_hold;
  assign busy           = r_busy;
  assign done           = r_done;
  assign err            = r_err;
  assign checksum       = r_checksum;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a write scoreboard and XOR checksum derived from the byte
// stream, checked every cycle, plus literal expectations for known programs.
module tb_imem_loader;
  localparam int DEPTH = 20;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W:0]   n_words;
  logic             core_hold, busy, done, err;
  logic [31:0]      checksum;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n_words   (n_words),
    .bus       (bus),
    .core_hold (core_hold),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          pulses = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_data = '0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  // Every-cycle compare against the write scoreboard and the output invariants.
  always @(negedge clk) begin
    chk("core_hold_is_not_done", {31'b0, core_hold}, {31'b0, ~done});
    chk("ready_only_when_busy", {31'b0, bus.byte_ready & ~busy}, 32'd0);
    if (bus.iwr_en === 1'b1) begin
      pulses++;
      last_addr = bus.iwr_addr;
      last_data = bus.iwr_data;
      if (exp_addr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %h data %h want no write", bus.iwr_addr, bus.iwr_data);
      end else begin
        chk("write_addr", bus.iwr_addr, exp_addr_q.pop_front());
        chk("write_data", bus.iwr_data, exp_data_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_byte_ready"}, {31'b0, bus.byte_ready}, 32'd0);
    chk({tag, "_iwr_en"},     {31'b0, bus.iwr_en},     32'd0);
    chk({tag, "_iwr_addr"},   bus.iwr_addr,            32'd0);
    chk({tag, "_iwr_data"},   bus.iwr_data,            32'd0);
    chk({tag, "_busy"},       {31'b0, busy},           32'd0);
    chk({tag, "_done"},       {31'b0, done},           32'd0);
    chk({tag, "_err"},        {31'b0, err},            32'd0);
    chk({tag, "_checksum"},   checksum,                32'd0);
    chk({tag, "_core_hold"},  {31'b0, core_hold},      32'd1);
  endtask

  task automatic do_start(input int n, input bit expect_ok);
    start   = 1'b1;
    n_words = (CNT_W+1)'(n);
    tick();
    start   = 1'b0;
    if (expect_ok) begin
      chk("start_ready",    {31'b0, bus.byte_ready}, 32'd1);
      chk("start_busy",     {31'b0, busy},           32'd1);
      chk("start_err_clr",  {31'b0, err},            32'd0);
      chk("start_done_clr", {31'b0, done},           32'd0);
      chk("start_csum_clr", checksum,                32'd0);
    end else begin
      chk("bad_err",       {31'b0, err},            32'd1);
      chk("bad_core_hold", {31'b0, core_hold},      32'd1);
      chk("bad_ready",     {31'b0, bus.byte_ready}, 32'd0);
      chk("bad_done",      {31'b0, done},           32'd0);
    end
  endtask

  // gap < 0 selects a random 0..3 idle cycles after each byte.
  task automatic send_bytes(input logic [7:0] b[$], input int gap, input int start_at, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < b.size(); i++) begin
      int g;
      int waitc;
      bit rdy;
      bus.byte_valid = 1'b1;
      bus.byte_in    = b[i];
      if (i == start_at) begin
        start   = 1'b1;
        n_words = (CNT_W+1)'(5);
      end
      waitc = 0;
      do begin
        rdy = bus.byte_ready;
        tick();
        start = 1'b0;
        waitc++;
      end while (!rdy && waitc < 40);
      bus.byte_valid = 1'b0;
      if (!rdy) begin
        total++;
        bad++;
        $display("FAIL byte_accept: got no byte_ready want ready within 40 cycles");
        ok = 1'b0;
        return;
      end
      if (i % 4 == 3) begin
        chk("iwr_en_after_4th",   {31'b0, bus.iwr_en},     32'd1);
        chk("ready_low_in_write", {31'b0, bus.byte_ready}, 32'd0);
      end
      g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
      repeat (g) tick();
    end
  endtask

  task automatic run_session(input logic [7:0] b[$], input int gap, input int start_at);
    int          n;
    logic [31:0] csum;
    bit          ok;
    n    = b.size() / 4;
    csum = '0;
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      logic [31:0] w;
      w = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
      exp_addr_q.push_back(32'(k * 4));
      exp_data_q.push_back(w);
      csum ^= w;
    end
    do_start(n, 1'b1);
    send_bytes(b, gap, start_at, ok);
    if (ok) begin
      tick();
      chk("end_done",      {31'b0, done},      32'd1);
      chk("end_core_hold", {31'b0, core_hold}, 32'd0);
      chk("end_busy",      {31'b0, busy},      32'd0);
      chk("end_checksum",  checksum,           csum);
      chk("end_pulses",    32'(pulses),        32'(n));
      chk("end_pending",   32'(exp_addr_q.size()), 32'd0);
    end
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  function automatic void rand_bytes(input int n, output logic [7:0] b[$]);
    b.delete();
    for (int i = 0; i < 4 * n; i++) b.push_back(8'($urandom));
  endfunction

  initial begin
    logic [7:0] b[$];
    bit         ok;

    rst = 1'b1;
    start = 1'b0;
    n_words = '0;
    bus.byte_valid = 1'b0;
    bus.byte_in = '0;
    repeat (2) tick();
    rst = 1'b0;
    check_reset_vals("reset");

    // Basic load, back-to-back bytes.
    b = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_session(b, 0, -1);
    chk("basic_csum_lit", checksum,  32'h0000_0580);
    chk("basic_addr_lit", last_addr, 32'h0000_0004);
    chk("basic_data_lit", last_data, 32'h0010_0093);

    // Same program with 3 idle cycles between bytes.
    run_session(b, 3, -1);
    chk("gap_csum_lit", checksum, 32'h0000_0580);

    // Rejected counts, then recovery.
    pulses = 0;
    do_start(0, 1'b0);
    tick();
    chk("err_held", {31'b0, err}, 32'd1);
    do_start(DEPTH + 1, 1'b0);
    repeat (3) tick();
    chk("err_no_writes", 32'(pulses), 32'd0);
    b = '{8'h6F, 8'h00, 8'h00, 8'h00};
    run_session(b, 0, -1);
    chk("recover_data_lit", last_data, 32'h0000_006F);
    chk("recover_addr_lit", last_addr, 32'h0000_0000);

    // Full depth, word i = i+1.
    b.delete();
    for (int i = 0; i < DEPTH; i++) begin
      b.push_back(8'(i + 1));
      b.push_back(8'h00);
      b.push_back(8'h00);
      b.push_back(8'h00);
    end
    run_session(b, 0, -1);
    chk("full_addr_lit", last_addr, 32'h0000_004C);
    chk("full_data_lit", last_data, 32'h0000_0014);
    chk("full_csum_lit", checksum,  32'h0000_0014);

    // Reset after two bytes of the first word.
    pulses = 0;
    do_start(1, 1'b1);
    b = '{8'hAA, 8'h55};
    send_bytes(b, 0, -1, ok);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_vals("midreset");
    repeat (3) tick();
    chk("midreset_no_write", 32'(pulses), 32'd0);
    rand_bytes(2, b);
    run_session(b, 1, -1);

    // start pulsed during RECV is ignored; then restart after DONE.
    rand_bytes(3, b);
    run_session(b, 1, 2);
    rand_bytes(1, b);
    run_session(b, 0, -1);
    chk("restart_addr_lit", last_addr, 32'h0000_0000);

    // Randomized sessions with random gaps.
    repeat (6) begin
      rand_bytes(int'($urandom_range(DEPTH, 1)), b);
      run_session(b, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the instruction memory before the core runs. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written into the instruction memory through that memory's upload port: write enable, data and word-aligned byte address. While loading, the block holds the core stalled, and it reports completion, error and a running XOR checksum.

## Interface
Parameters:
- DEPTH, 20, instruction memory depth in words
- CNT_W, 5, width of word counter/index; must satisfy 2^CNT_W ≥ DEPTH+1

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a load session; sampled only in IDLE, DONE, ERR
- n_words  in  CNT_W+1  words to load; sampled with start
- byte_valid  in  1  byte_in valid
- byte_in  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- iwr_en  out  1  instruction memory write enable, one-cycle pulse per word
- iwr_addr  out  32  byte address of word (word index × 4, bits [1:0]=0)
- iwr_data  out  32  assembled instruction word
- core_hold  out  1  keep core stalled
- busy  out  1  session in progress (RECV or WRITE)
- done  out  1  all words written
- err  out  1  rejected n_words
- checksum  out  32  XOR of all words written this session

## Operation
- States: IDLE, RECV, WRITE, DONE, ERR.
- Reset (rst=1 at an edge): state=IDLE. Outputs: byte_ready=0, iwr_en=0, iwr_addr=0, iwr_data=0, busy=0, done=0, err=0, checksum=0, core_hold=1. Byte and word counters cleared; partial word discarded. rst has priority over every other input.
- IDLE/DONE/ERR with start=1:
  - If 1 ≤ n_words ≤ DEPTH: latch n_words, clear word index, byte count, checksum, done and err, then go to RECV.
  - Otherwise: go to ERR.
- start in RECV or WRITE is ignored.
- RECV:
  - byte_ready=1.
  - A byte is accepted when byte_valid && byte_ready.
  - Byte k (k = 0..3) goes to word bits [8k+7:8k]; first byte is the LSB.
  - The 4th accepted byte moves the state to WRITE.
  - byte_valid gaps stall without side effects.
- WRITE, exactly one cycle:
  - iwr_en=1, iwr_data=assembled word, iwr_addr={word_index,2'b00} zero-extended; byte_ready=0.
  - On exit: checksum ^= word, word_index += 1.
  - If the written index equals n_words−1, go to DONE; else go to RECV with byte count cleared.
- DONE: done=1, core_hold=0. Held until start or rst.
- ERR: err=1, core_hold=1. No writes are issued. Held until start or rst.
- core_hold: 1 in IDLE, RECV, WRITE and ERR; 0 only in DONE.
- busy: 1 in RECV and WRITE.
- iwr_addr and iwr_data hold their last written values outside WRITE; they are only meaningful when iwr_en=1.
- Addresses never exceed (DEPTH−1)×4; no wrap-around is possible because n_words is validated.

## Timing
- All outputs are registered from state.
- start accepted at edge N: byte_ready=1 from cycle N+1 (or err=1 from N+1 on a bad count).
- 4th byte of a word accepted at edge M: iwr_en=1 in cycle M+1; byte_ready=0 in cycle M+1.
- Next word's first byte can be accepted at edge M+2.
- Peak throughput: 1 word per 5 cycles.
- Last write in cycle W: done=1 and core_hold=0 from cycle W+1; checksum is final in W+1.
- A byte presented during WRITE is not accepted; the source must hold it until byte_ready.
- rst asserted mid-session: the next cycle shows reset values; no iwr_en pulse for a partial word.

## Test plan
- Basic load: rst, start with n_words=2, bytes 13 05 10 00 93 00 10 00 (valid every cycle) → iwr_en pulses with addr 0x0/data 0x00100513, then addr 0x4/data 0x00100093; exactly 2 pulses; done=1, core_hold=0, checksum=0x00000580.
- Gapped stream: same bytes with byte_valid low for 3 cycles between every byte → identical writes and checksum; no extra iwr_en; a byte offered during WRITE is held and accepted next cycle.
- Bad count: start with n_words=0 → err=1 next cycle, core_hold=1, no iwr_en. Start with n_words=21 → err=1. Then start with n_words=1 and bytes 6F 00 00 00 → err clears, write 0x0000006F at addr 0x0, done=1.
- Full depth: n_words=20 with word i = i+1 → 20 pulses, last addr 0x4C, data 0x00000014; done=1; checksum = XOR of 1..20 = 0x00000014.
- Reset mid-word: after 2 bytes of the first word, rst for 1 cycle → no iwr_en, state IDLE, core_hold=1, all counters 0. New session starts cleanly at addr 0x0.
- Restart/ignore: start pulsed during RECV → no effect on addr/data sequence. start after DONE with n_words=1 → done drops next cycle, write at addr 0x0, checksum restarts from 0.
